// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR latch pulse driver.
//   drv_state_t    : FSM state encoding (IDLE / PULSE / GAP)
//   DEF_PULSE_CYC  : default set/reset pulse width in clk cycles
//   DEF_GAP_CYC    : default settle gap after the pulse in clk cycles
//   MIN_GAP        : smallest legal gap; the gap must outlast the two-flop
//                    feedback synchronizer so the checked Q is post-pulse
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } drv_state_t;

  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_GAP_CYC   = 4;
  localparam int MIN_GAP       = 3;

endpackage

// File: rtl/sr_pulse_driver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronized output, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/sr_pulse_driver.sv
// Drives an external SR-style latch from a level command. Every accepted
// command becomes one set or reset pulse of PULSE_CYC cycles, followed by a
// GAP_CYC settle gap, after which the synchronized latch Q is compared with
// the commanded level and done (plus err on mismatch) pulses for one cycle.
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   cmd_valid  : command request
//   cmd_level  : requested latch state (1 = set, 0 = reset)
//   cmd_ready  : high when idle and able to accept a command
//   set_out    : registered S drive
//   rst_out    : registered R drive
//   q_fb       : asynchronous Q fed back from the latch
//   done       : one-cycle pulse at the end of each command
//   err        : one-cycle pulse with done when Q differs from the command
//   level_q    : last accepted cmd_level
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  output logic set_out,
  output logic rst_out,
  input  logic q_fb,
  output logic done,
  output logic err,
  output logic level_q
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  if (GAP_CYC < MIN_GAP) begin : g_gap_chk
    $error("GAP_CYC (%0d) must be at least %0d", GAP_CYC, MIN_GAP);
  end
  if (PULSE_CYC < 1) begin : g_pulse_chk
    $error("PULSE_CYC (%0d) must be at least 1", PULSE_CYC);
  end

  drv_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             q_sync;
  logic             accept;
  logic             pulse_end;
  logic             gap_end;

  logic             ready_nxt;
  logic             set_nxt;
  logic             rst_nxt;
  logic             done_nxt;
  logic             err_nxt;
  logic             level_nxt;

  sync_2ff u_q_sync (
    .clk (clk),
    .rst (rst),
    .d   (q_fb),
    .q   (q_sync)
  );

  assign accept    = cmd_valid && cmd_ready;
  assign pulse_end = (cnt == PULSE_LAST);
  assign gap_end   = (cnt == GAP_LAST);

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      set_out   <= 1'b0;
      rst_out   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd_ready <= ready_nxt;
      set_out   <= set_nxt;
      rst_out   <= rst_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      level_q   <= level_nxt;
    end
  end

  // Next-state and phase counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = PULSE;
          cnt_nxt   = '0;
        end
      end
      PULSE: begin
        if (pulse_end) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_end) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Next output values; drives default to 0 so they can never overlap and
  // are guaranteed low in IDLE and GAP.
  always_comb begin
    ready_nxt = cmd_ready;
    set_nxt   = 1'b0;
    rst_nxt   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    level_nxt = level_q;
    case (state)
      IDLE: begin
        if (accept) begin
          ready_nxt = 1'b0;
          set_nxt   = cmd_level;
          rst_nxt   = ~cmd_level;
          level_nxt = cmd_level;
        end
      end
      PULSE: begin
        if (!pulse_end) begin
          set_nxt = set_out;
          rst_nxt = rst_out;
        end
      end
      GAP: begin
        if (gap_end) begin
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
          err_nxt   = (q_sync != level_q);
        end
      end
      default: begin
        ready_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
module tb_sr_pulse_driver;

  localparam int P = 4;
  localparam int G = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_level = 1'b0;
  logic cmd_ready, set_out, rst_out, q_fb, done, err, level_q;

  always #5 clk = ~clk;

  sr_pulse_driver #(.PULSE_CYC(P), .GAP_CYC(G), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_level (cmd_level),
    .cmd_ready (cmd_ready),
    .set_out   (set_out),
    .rst_out   (rst_out),
    .q_fb      (q_fb),
    .done      (done),
    .err       (err),
    .level_q   (level_q)
  );

  // Latch model: Q follows the drives one cycle later, optionally stuck at 0.
  logic latch_q = 1'b0;
  bit   stuck   = 1'b0;
  always @(posedge clk) begin
    if (stuck)        latch_q <= 1'b0;
    else if (set_out) latch_q <= 1'b1;
    else if (rst_out) latch_q <= 1'b0;
  end
  assign q_fb = latch_q;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_no, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, act, exp);
    end
  endtask

  // Reference model: a command is a transaction with an accept edge; every
  // output is a function of the distance k from that edge.
  bit m_busy = 1'b0;
  int m_acc = 0;
  bit m_lvl = 1'b0;
  bit m_lvq = 1'b0;
  int m_last_rst = -100;
  bit m_started = 1'b0;
  bit e_set, e_rst, e_ready, e_done, e_err, m_qs;
  int m_k;
  bit qhist [0:16383];

  initial begin
    forever begin
      @(posedge clk);
      edge_no++;
      qhist[edge_no] = q_fb;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (rst) begin
        m_busy = 1'b0;
        m_lvq = 1'b0;
        m_last_rst = edge_no;
        m_started = 1'b1;
      end else if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1'b1;
          m_acc = edge_no;
          m_lvl = cmd_level;
          m_lvq = cmd_level;
        end
      end else if (edge_no - m_acc == P + G) begin
        m_busy = 1'b0;
        e_done = 1'b1;
        // The compared Q is the one sampled two edges earlier, unless the
        // synchronizer was cleared since then.
        m_qs = (edge_no - 2 > m_last_rst) ? qhist[edge_no - 2] : 1'b0;
        e_err = (m_qs != m_lvl);
      end
      m_k = edge_no - m_acc;
      e_set   = m_busy && (m_k < P) && m_lvl;
      e_rst   = m_busy && (m_k < P) && !m_lvl;
      e_ready = !m_busy;
      #1;
      if (m_started) begin
        chk("cmd_ready", cmd_ready, e_ready);
        chk("set_out", set_out, e_set);
        chk("rst_out", rst_out, e_rst);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("level_q", level_q, m_lvq);
        chk("no_overlap", set_out && rst_out, 1'b0);
      end
    end
  end

  task automatic cyc(input bit v, input bit l, input bit r);
    @(negedge clk);
    cmd_valid = v;
    cmd_level = l;
    rst = r;
  endtask

  // Issues one command and checks pulse width, done timing and result.
  task automatic one_cmd(input string tag, input bit l, input bit exp_err);
    int e0, ns, nr, nd, ne, done_at;
    logic lv;
    cyc(1'b1, l, 1'b0);
    @(posedge clk); #1;
    e0 = edge_no;
    ns = int'(set_out);
    nr = int'(rst_out);
    nd = 0; ne = 0; done_at = -1; lv = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      ns += int'(set_out);
      nr += int'(rst_out);
      ne += int'(err);
      if (done) begin
        nd++;
        done_at = edge_no - e0;
        lv = level_q;
      end
    end
    chk_int({tag, "_set_cycles"}, ns, l ? 4 : 0);
    chk_int({tag, "_rst_cycles"}, nr, l ? 0 : 4);
    chk_int({tag, "_done_count"}, nd, 1);
    chk_int({tag, "_done_edge"}, done_at, 8);
    chk_int({tag, "_err_cycles"}, ne, exp_err ? 1 : 0);
    chk({tag, "_level_q"}, lv, l);
  endtask

  int acc_edges[$];
  int nd_abort;

  initial begin
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("reset_ready", cmd_ready, 1'b1);
    chk("reset_set", set_out, 1'b0);
    chk("reset_rst", rst_out, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_level", level_q, 1'b0);

    one_cmd("set", 1'b1, 1'b0);
    one_cmd("clr", 1'b0, 1'b0);
    stuck = 1'b1;
    one_cmd("stuck", 1'b1, 1'b1);
    stuck = 1'b0;
    one_cmd("set2", 1'b1, 1'b0);
    one_cmd("already_set", 1'b1, 1'b0);

    // Continuous requests with alternating levels
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_level = i[0];
      rst = 1'b0;
      if (cmd_ready) acc_edges.push_back(edge_no + 1);
    end
    cyc(1'b0, 1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0);
    chk_int("stream_accepts", acc_edges.size(), 5);
    for (int i = 1; i < acc_edges.size(); i++)
      chk_int("stream_spacing", acc_edges[i] - acc_edges[i-1], 9);

    // Reset while the set pulse is in progress at counter 2
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("abort_pre_set", set_out, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("abort_set", set_out, 1'b0);
    chk("abort_ready", cmd_ready, 1'b1);
    chk("abort_level", level_q, 1'b0);
    nd_abort = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      nd_abort += int'(done);
    end
    chk_int("abort_no_done", nd_abort, 0);
    one_cmd("after_abort", 1'b1, 1'b0);

    // Randomized traffic checked by the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) stuck = ~stuck;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 63) == 0));
    end
    cyc(1'b0, 1'b0, 1'b0);
    repeat (12) cyc(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_pulse_driver.md
# sr_pulse_driver

Drives an external set/reset latch from a registered level command. It turns each accepted command into a single, non-overlapping set or reset pulse of fixed width, followed by a settle gap. It then checks the latch's fed-back Q against the commanded level. The block sits between control logic, which issues level requests, and any SR-style storage element, such as a latching relay or the team's sr_latch.

## Interface
Parameters:
- PULSE_CYC, default 4: width of the set or reset pulse in clk cycles; legal range 1..2^CNT_W-1.
- GAP_CYC, default 4: settle gap after the pulse, in cycles; legal range 3..2^CNT_W-1 (it must cover the feedback synchronizer).
- CNT_W, default 8: width of the shared phase counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_level  in  1  requested latch state: 1 = set, 0 = reset.
- cmd_ready  out  1  registered; high when idle and able to accept a command.
- set_out  out  1  registered S drive to the latch.
- rst_out  out  1  registered R drive to the latch.
- q_fb  in  1  asynchronous Q from the latch.
- done  out  1  one-cycle pulse at the end of each command.
- err  out  1  one-cycle pulse, coincident with done, when the synchronized q_fb does not equal the commanded level.
- level_q  out  1  last accepted cmd_level.

## Operation
- Reset values: cmd_ready=1, set_out=0, rst_out=0, done=0, err=0, level_q=0. State is IDLE, the counter is 0 and both synchronizer flops are 0.
- States: IDLE, PULSE, GAP.
- IDLE:
  - The handshake accepts a command when cmd_valid && cmd_ready at a clock edge.
  - On accept: latch level_q=cmd_level, drive set_out=cmd_level and rst_out=~cmd_level, clear cmd_ready, load the counter with 0 and go to PULSE.
- PULSE: the counter increments each cycle. When the counter reaches PULSE_CYC-1, both drives go to 0, the counter goes to 0 and the state goes to GAP.
- GAP:
  - Both drives stay at 0 and the counter increments.
  - When the counter reaches GAP_CYC-1, the state goes to IDLE. On that same edge, cmd_ready=1, done=1 and err=(q_sync != level_q).
- Invariants:
  - set_out && rst_out is never 1.
  - Both drives are 0 in IDLE and GAP.
  - A command whose level equals the current Q still produces a full pulse, gap and check; the block keeps no redundant-command suppression.
- cmd_valid while cmd_ready=0 is ignored; it is not queued. cmd_level is sampled only on the accept edge.
- q_fb passes through a two-flop synchronizer; only the synchronized value q_sync is compared.
- Reset mid-operation: at the next edge every output returns to its reset value. No done is produced and the in-flight command is lost.
- Counter arithmetic is unsigned CNT_W. The parameter ranges above guarantee no wrap-around.

## Timing
- Accept at edge E0. set_out or rst_out is high after edges E0..E(P-1), i.e. exactly P=PULSE_CYC cycles, and low after E(P).
- done, err and cmd_ready=1 are asserted after edge E(P+G), where G=GAP_CYC.
- Command-to-done latency is P+G cycles.
- The earliest next accept is E(P+G+1), giving a throughput of one command per P+G+1 cycles.
- done holds for exactly one cycle.
- The q_fb value compared is the one present at least 2 edges before E(P+G). GAP_CYC>=3 guarantees this samples the latch after the pulse has ended.

## Structure
- Package sr_drv_pkg holds:
  - the state enum: IDLE=2'd0, PULSE=2'd1, GAP=2'd2;
  - the default values of PULSE_CYC and GAP_CYC;
  - the minimum-gap constant MIN_GAP=3, which the module checks with an elaboration-time assertion.
- One sub-module, sync_2ff, provides the q_fb synchronizer (1-bit, reset to 0).
- The FSM, counter and output registers live in sr_pulse_driver.

## Test plan
All scenarios use PULSE_CYC=4 and GAP_CYC=4. The bench models the latch with a 1-cycle Q response.
- Reset, then cmd_level=1 accepted at E0:
  - set_out high for exactly 4 cycles and rst_out stays 0;
  - done=1 after E8 with err=0 and level_q=1.
- With the latch set, cmd_level=0:
  - rst_out high for 4 cycles;
  - done after E8 with err=0;
  - set_out never high.
- Latch model stuck at 0, cmd_level=1: done and err both 1 after E8, each for exactly 1 cycle.
- cmd_valid held high continuously with alternating levels:
  - accepts land exactly 9 cycles apart;
  - requests during busy are ignored;
  - set_out && rst_out is never observed (asserted every cycle).
- rst pulsed during PULSE at counter=2:
  - next cycle set_out=0, cmd_ready=1;
  - done never fires for the aborted command;
  - the next command completes normally.
- cmd_level=1 when the latch is already set: a full 4-cycle set pulse is issued, then done with err=0.
